// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/sequencing controller:
// mult/div FSM encoding, default latencies and the hardwired zero register.
package pipe_ctrl_pkg;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    localparam logic [4:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/pipe_ctrl_md_busy_ctr.sv
// Busy tracker for the multi-cycle mult/div unit: IDLE/BUSY FSM plus a
// down-counter that holds busy for exactly N cycles after the start cycle.
module md_busy_ctr
    import pipe_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    input  logic cancel,
    output logic busy
);

    md_state_e        state_p0, state_nxt;
    logic [CNT_W-1:0] cnt_p0, cnt_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_p0 <= MD_IDLE;
            cnt_p0   <= '0;
        end else begin
            state_p0 <= state_nxt;
            cnt_p0   <= cnt_nxt;
        end
    end

    // A start seen while BUSY is ignored: the running count is kept.
    always_comb begin
        state_nxt = state_p0;
        cnt_nxt   = cnt_p0;
        unique case (state_p0)
            MD_IDLE: begin
                if (start && !cancel) begin
                    state_nxt = MD_BUSY;
                    cnt_nxt   = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                end
            end
            MD_BUSY: begin
                if (cnt_p0 == CNT_W'(1)) begin
                    state_nxt = MD_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_p0 - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = MD_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        busy = (state_p0 == MD_BUSY);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard and sequencing controller for the five-stage pipeline: load-use and
// HI/LO stalls, mult/div busy tracking, and exception flush/redirect.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       id_is_md,
    input  logic       ex_is_load,
    input  logic [4:0] ex_wa,
    input  logic       ex_md_start,
    input  logic       ex_md_div,
    input  logic       exc_req,
    output logic       pc_en,
    output logic       if_id_en,
    output logic       if_id_flush,
    output logic       id_ex_flush,
    output logic       ex_mem_flush,
    output logic       exc_redirect,
    output logic       md_busy,
    output logic       stall
);

    logic lu;
    logic mdh;
    logic stall_raw;

    // An exception in the same cycle as a start flushes that instruction,
    // so the start must not reach the busy tracker.
    md_busy_ctr #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_busy_ctr (
        .clk    (clk),
        .reset  (reset),
        .start  (ex_md_start),
        .is_div (ex_md_div),
        .cancel (exc_req),
        .busy   (md_busy)
    );

    always_comb begin
        lu = ex_is_load && (ex_wa != ZERO_REG) &&
             ((id_use_rs && (id_rs == ex_wa)) || (id_use_rt && (id_rt == ex_wa)));
        mdh       = id_is_md && (md_busy || ex_md_start);
        stall_raw = lu || mdh;
    end

    // Exception outranks every stall: the faulting path is flushed and the
    // PC must advance to the handler.
    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        exc_redirect = 1'b0;
        stall        = 1'b0;
        if (exc_req) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            exc_redirect = 1'b1;
        end else if (stall_raw) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
            stall       = 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus a randomized run
// against a cycle-level reference model of the hazard and busy rules.
module tb_pipe_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_wa;
    logic       id_use_rs, id_use_rt, id_is_md, ex_is_load;
    logic       ex_md_start, ex_md_div, exc_req;
    logic       pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_flush;
    logic       exc_redirect, md_busy, stall;

    int tests = 0;
    int fails = 0;
    int rem   = 0;   // model: busy cycles still to come

    always #5 clk = ~clk;

    pipe_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .id_is_md     (id_is_md),
        .ex_is_load   (ex_is_load),
        .ex_wa        (ex_wa),
        .ex_md_start  (ex_md_start),
        .ex_md_div    (ex_md_div),
        .exc_req      (exc_req),
        .pc_en        (pc_en),
        .if_id_en     (if_id_en),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_flush (ex_mem_flush),
        .exc_redirect (exc_redirect),
        .md_busy      (md_busy),
        .stall        (stall)
    );

    // Output vector order: pc_en if_id_en if_id_flush id_ex_flush ex_mem_flush exc_redirect md_busy stall
    function automatic logic [7:0] outs();
        return {pc_en, if_id_en, if_id_flush, id_ex_flush,
                ex_mem_flush, exc_redirect, md_busy, stall};
    endfunction

    function automatic logic [7:0] model_exp();
        logic busy, hz_load, hz_md;
        busy    = (rem > 0);
        hz_load = ex_is_load && (ex_wa != 0) &&
                  ((id_use_rs && id_rs == ex_wa) || (id_use_rt && id_rt == ex_wa));
        hz_md   = id_is_md && (busy || ex_md_start);
        if (exc_req)              return {6'b111111, busy, 1'b0};
        else if (hz_load || hz_md) return {6'b000100, busy, 1'b1};
        else                      return {6'b110000, busy, 1'b0};
    endfunction

    task automatic clear_inputs();
        id_rs = 0; id_rt = 0; ex_wa = 0;
        id_use_rs = 0; id_use_rt = 0; id_is_md = 0; ex_is_load = 0;
        ex_md_start = 0; ex_md_div = 0; exc_req = 0;
    endtask

    // Advance one clock and update the model from the inputs seen at that edge.
    task automatic tick();
        @(posedge clk);
        if (rem > 0) rem = rem - 1;
        else if (ex_md_start && !exc_req) rem = ex_md_div ? 10 : 5;
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] o;
        reset = 1'b0;
        clear_inputs();
        #2;
        o = outs(); tests++;
        if (o !== 8'b1100_0000) begin
            fails++; $display("FAIL reset_outs: got %b expected %b", o, 8'b1100_0000);
        end
        @(posedge clk); #1;
        o = outs(); tests++;
        if (o !== 8'b1100_0000) begin
            fails++; $display("FAIL reset_held: got %b expected %b", o, 8'b1100_0000);
        end
        @(negedge clk); reset = 1'b1; rem = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_load_use();
        // {ex_is_load, ex_wa, id_use_rs, id_rs, id_use_rt, id_rt, expect_stall}
        logic [19:0] tbl [6];
        logic [7:0]  o, e;
        tbl[0] = {1'b1, 5'd8, 1'b1, 5'd8, 1'b0, 5'd0, 1'b1};
        tbl[1] = {1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0};
        tbl[2] = {1'b1, 5'd9, 1'b0, 5'd0, 1'b1, 5'd9, 1'b1};
        tbl[3] = {1'b1, 5'd9, 1'b0, 5'd9, 1'b0, 5'd9, 1'b0};
        tbl[4] = {1'b0, 5'd8, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0};
        tbl[5] = {1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            clear_inputs();
            {ex_is_load, ex_wa, id_use_rs, id_rs, id_use_rt, id_rt} = tbl[i][19:1];
            #2;
            e = tbl[i][0] ? 8'b0001_0001 : 8'b1100_0000;
            o = outs(); tests++;
            if (o !== e) begin
                fails++; $display("FAIL load_use[%0d]: got %b expected %b", i, o, e);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_mult_timing();
        clear_inputs();
        id_is_md = 1; ex_md_start = 1; ex_md_div = 0;
        #2; tests++;
        if ({md_busy, stall} !== 2'b01) begin
            fails++; $display("FAIL mult_start_cycle: busy,stall got %b expected 01", {md_busy, stall});
        end
        tick();
        ex_md_start = 0;
        for (int i = 1; i <= 5; i++) begin
            #2; tests++;
            if ({md_busy, stall} !== 2'b11) begin
                fails++; $display("FAIL mult_busy[T+%0d]: busy,stall got %b expected 11", i, {md_busy, stall});
            end
            tick();
        end
        #2; tests++;
        if ({md_busy, stall} !== 2'b00) begin
            fails++; $display("FAIL mult_release: busy,stall got %b expected 00", {md_busy, stall});
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_div_timing();
        int busy_cnt = 0;
        int stall_cnt = 0;
        clear_inputs();
        ex_md_start = 1; ex_md_div = 1;
        tick();
        clear_inputs();
        for (int i = 1; i <= 13; i++) begin
            #2;
            if (md_busy) busy_cnt++;
            if (stall) stall_cnt++;
            if (i == 11) begin
                tests++;
                if (md_busy !== 1'b0) begin
                    fails++; $display("FAIL div_end: busy at T+11 got %b expected 0", md_busy);
                end
            end
            tick();
        end
        tests++;
        if (busy_cnt != 10) begin
            fails++; $display("FAIL div_busy_len: got %0d expected 10", busy_cnt);
        end
        tests++;
        if (stall_cnt != 0) begin
            fails++; $display("FAIL div_no_stall: stall cycles got %0d expected 0", stall_cnt);
        end
    endtask

    task automatic test_exc_priority();
        logic [7:0] o;
        clear_inputs();
        ex_is_load = 1; ex_wa = 5'd12; id_use_rt = 1; id_rt = 5'd12; exc_req = 1;
        #2; o = outs(); tests++;
        if (o !== 8'b1111_1100) begin
            fails++; $display("FAIL exc_over_lu: got %b expected %b", o, 8'b1111_1100);
        end
        tick();
        clear_inputs();
        exc_req = 1;
        #2; o = outs(); tests++;
        if (o !== 8'b1111_1100) begin
            fails++; $display("FAIL exc_plain: got %b expected %b", o, 8'b1111_1100);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_exc_md();
        logic [7:0] o;
        clear_inputs();
        exc_req = 1; ex_md_start = 1; ex_md_div = 1;
        tick();
        clear_inputs();
        #2; tests++;
        if (md_busy !== 1'b0) begin
            fails++; $display("FAIL exc_cancel_start: busy got %b expected 0", md_busy);
        end
        tick();
        ex_md_start = 1;
        tick();
        ex_md_start = 0;
        for (int i = 1; i <= 6; i++) begin
            exc_req = (i == 3);
            #2;
            if (i == 3) begin
                o = outs(); tests++;
                if (o !== 8'b1111_1110) begin
                    fails++; $display("FAIL exc_during_busy: got %b expected %b", o, 8'b1111_1110);
                end
            end
            tests++;
            if (md_busy !== (i <= 5)) begin
                fails++; $display("FAIL busy_schedule[T+%0d]: got %b expected %b", i, md_busy, (i <= 5));
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_async_reset();
        logic [7:0] o;
        clear_inputs();
        ex_md_start = 1; ex_md_div = 1;
        tick();
        clear_inputs();
        tick();
        #2;
        tests++;
        if (md_busy !== 1'b1) begin
            fails++; $display("FAIL pre_reset_busy: got %b expected 1", md_busy);
        end
        reset = 1'b0; rem = 0;
        #1;
        o = outs(); tests++;
        if (o !== 8'b1100_0000) begin
            fails++; $display("FAIL async_reset: got %b expected %b", o, 8'b1100_0000);
        end
        @(negedge clk); reset = 1'b1;
        tick();
        o = outs(); tests++;
        if (o !== 8'b1100_0000) begin
            fails++; $display("FAIL post_reset: got %b expected %b", o, 8'b1100_0000);
        end
    endtask

    task automatic test_random();
        logic [7:0] o, e;
        for (int n = 0; n < 400; n++) begin
            id_rs      = 5'($urandom_range(0, 3));
            id_rt      = 5'($urandom_range(0, 3));
            ex_wa      = 5'($urandom_range(0, 3));
            id_use_rs  = 1'($urandom);
            id_use_rt  = 1'($urandom);
            id_is_md   = 1'($urandom);
            ex_is_load = 1'($urandom);
            ex_md_div  = 1'($urandom);
            ex_md_start = (rem == 0) && ($urandom_range(0, 5) == 0);
            exc_req    = ($urandom_range(0, 7) == 0);
            #2;
            tests++;
            if (ex_md_start && md_busy) begin
                fails++; $display("FAIL illegal_start[%0d]: start=%b busy=%b expected no overlap", n, ex_md_start, md_busy);
            end
            o = outs(); e = model_exp(); tests++;
            if (o !== e) begin
                fails++; $display("FAIL random[%0d]: got %b expected %b", n, o, e);
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        test_reset();
        test_load_use();
        test_mult_timing();
        test_div_timing();
        test_exc_priority();
        test_exc_md();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
